// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the instruction-side page-table walker.
//   - walker FSM state encoding
//   - PDE/PTE flag bit positions
//   - VPN/PPN field ranges and the table-entry address helper
package mmu_pkg;

   localparam int PGD_W  = 20;
   localparam int VPN_W  = 20;
   localparam int PPN_W  = 20;
   localparam int ADDR_W = 32;

   // entry flag bits (PDE and PTE share V; L is PDE only, X both)
   localparam int PTE_V = 0;
   localparam int PTE_L = 1;
   localparam int PTE_X = 2;

   // entry PPN / next-level base field
   localparam int PPN_HI = 31;
   localparam int PPN_LO = 12;
   // superpage frame field of a leaf PDE
   localparam int SP_HI  = 31;
   localparam int SP_LO  = 22;

   // fields inside the 20-bit VPN (VA[31:22] and VA[21:12])
   localparam int VPN1_HI = 19;
   localparam int VPN1_LO = 10;
   localparam int VPN0_HI = 9;
   localparam int VPN0_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_REQ,
      S_L1_WAIT,
      S_L2_REQ,
      S_L2_WAIT,
      S_RESP,
      S_DRAIN
   } walk_state_t;

   // byte address of a 4-byte table entry: {table base, index, 2'b00}
   function automatic logic [ADDR_W-1:0] pt_addr(input logic [19:0] base,
                                                 input logic [9:0]  idx);
      return {base, idx, 2'b00};
   endfunction

endpackage

// File: rtl/i_tlb_walker_if.sv
// i_tlb_walker_if: dedicated page-table memory read port.
//   mem_req/mem_addr : read request, held until mem_gnt
//   mem_gnt          : request accepted this cycle
//   mem_rvalid/rdata : in-order read data, at least one cycle after grant
// master = walker side, slave = memory side.
interface i_tlb_walker_if;
   import mmu_pkg::*;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [ADDR_W-1:0] mem_rdata;

   modport master (output mem_req, mem_addr,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_addr,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/i_tlb_walker.sv
// i_tlb_walker: two-level hardware page-table walker behind the I-TLB.
//   clk, rst                   : clock, synchronous active-high reset
//   pgd_base                   : page-directory base [31:12], latched on accept
//   flush                      : abandon the walk in flight
//   I_TLB_2_MMU_en / _VPN_2_MMU: miss request (level) and missing VPN
//   I_TLB_PPN_from_MMU_en      : one-cycle response pulse
//   I_TLB_PPN_from_MMU / _page_fault : result, valid with the pulse
//   walker_busy                : high whenever the FSM is not idle
//   mem                        : page-table read port (master side)
// One walk at a time; all outputs come from registers except that a flush in
// the response cycle masks the pulse.
module i_tlb_walker
   import mmu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [PGD_W-1:0] pgd_base,
   input  logic             flush,
   input  logic             I_TLB_2_MMU_en,
   input  logic [VPN_W-1:0] I_TLB_VPN_2_MMU,
   output logic             I_TLB_PPN_from_MMU_en,
   output logic [PPN_W-1:0] I_TLB_PPN_from_MMU,
   output logic             I_TLB_from_MMU_page_fault,
   output logic             walker_busy,
   i_tlb_walker_if.master   mem
);

   walk_state_t       r_state, w_nxt;
   logic [VPN_W-1:0]  r_vpn;
   logic [PGD_W-1:0]  r_pgd;
   logic [PPN_W-1:0]  r_pde_base;
   logic              r_req, w_req;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic              r_vld, w_vld;
   logic [PPN_W-1:0]  r_ppn, w_ppn;
   logic              r_fault, w_fault;
   logic              r_busy;
   logic              w_accept, w_lat_pde;
   logic [ADDR_W-1:0] w_rd;
   logic              w_unused_rdata;

   assign w_rd           = mem.mem_rdata;
   assign w_unused_rdata = ^w_rd[11:3];

   always_comb begin
      w_nxt     = r_state;
      w_req     = r_req;
      w_addr    = r_addr;
      w_vld     = 1'b0;
      w_ppn     = '0;
      w_fault   = 1'b0;
      w_accept  = 1'b0;
      w_lat_pde = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (I_TLB_2_MMU_en && !flush) begin
               w_accept = 1'b1;
               w_req    = 1'b1;
               w_addr   = pt_addr(pgd_base, I_TLB_VPN_2_MMU[VPN1_HI:VPN1_LO]);
               w_nxt    = S_L1_REQ;
            end
         end
         S_L1_REQ, S_L2_REQ: begin
            // hold the address from latched fields while waiting for grant
            w_addr = (r_state == S_L1_REQ) ? pt_addr(r_pgd, r_vpn[VPN1_HI:VPN1_LO])
                                           : pt_addr(r_pde_base, r_vpn[VPN0_HI:VPN0_LO]);
            if (mem.mem_gnt) begin
               // a granted read must be drained even if flushed now
               w_req = 1'b0;
               if (flush)                  w_nxt = S_DRAIN;
               else if (r_state == S_L1_REQ) w_nxt = S_L1_WAIT;
               else                        w_nxt = S_L2_WAIT;
            end else if (flush) begin
               w_req = 1'b0;
               w_nxt = S_IDLE;
            end
         end
         S_L1_WAIT: begin
            if (flush) begin
               w_nxt = mem.mem_rvalid ? S_IDLE : S_DRAIN;
            end else if (mem.mem_rvalid) begin
               if (!w_rd[PTE_V]) begin
                  w_vld   = 1'b1;
                  w_fault = 1'b1;
                  w_nxt   = S_RESP;
               end else if (w_rd[PTE_L]) begin
                  // 4 MB superpage: frame from PDE, low 10 VPN bits pass through
                  w_vld   = 1'b1;
                  w_fault = !w_rd[PTE_X];
                  w_ppn   = w_fault ? '0 : {w_rd[SP_HI:SP_LO], r_vpn[VPN0_HI:VPN0_LO]};
                  w_nxt   = S_RESP;
               end else begin
                  w_lat_pde = 1'b1;
                  w_req     = 1'b1;
                  w_addr    = pt_addr(w_rd[PPN_HI:PPN_LO], r_vpn[VPN0_HI:VPN0_LO]);
                  w_nxt     = S_L2_REQ;
               end
            end
         end
         S_L2_WAIT: begin
            if (flush) begin
               w_nxt = mem.mem_rvalid ? S_IDLE : S_DRAIN;
            end else if (mem.mem_rvalid) begin
               w_vld   = 1'b1;
               w_fault = !w_rd[PTE_V] || !w_rd[PTE_X];
               w_ppn   = w_fault ? '0 : w_rd[PPN_HI:PPN_LO];
               w_nxt   = S_RESP;
            end
         end
         S_RESP:  w_nxt = S_IDLE;
         S_DRAIN: if (mem.mem_rvalid) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_vpn      <= '0;
         r_pgd      <= '0;
         r_pde_base <= '0;
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_vld      <= 1'b0;
         r_ppn      <= '0;
         r_fault    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_req   <= w_req;
         r_addr  <= w_addr;
         r_vld   <= w_vld;
         r_ppn   <= w_ppn;
         r_fault <= w_fault;
         r_busy  <= (w_nxt != S_IDLE);
         if (w_accept) begin
            r_vpn <= I_TLB_VPN_2_MMU;
            r_pgd <= pgd_base;
         end
         if (w_lat_pde) r_pde_base <= w_rd[PPN_HI:PPN_LO];
      end
   end

   assign mem.mem_req               = r_req;
   assign mem.mem_addr              = r_addr;
   // flush in the response cycle cancels the install
   assign I_TLB_PPN_from_MMU_en     = r_vld && !flush;
   assign I_TLB_PPN_from_MMU        = r_ppn;
   assign I_TLB_from_MMU_page_fault = r_fault;
   assign walker_busy               = r_busy;

endmodule

// File: tb/tb_i_tlb_walker.sv
module tb_i_tlb_walker;
   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] pgd_base;
   logic        flush;
   logic        en;
   logic [19:0] vpn;
   logic        rsp_en;
   logic [19:0] rsp_ppn;
   logic        rsp_fault;
   logic        busy;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   i_tlb_walker_if mem_if();

   i_tlb_walker dut (
      .clk                       (clk),
      .rst                       (rst),
      .pgd_base                  (pgd_base),
      .flush                     (flush),
      .I_TLB_2_MMU_en            (en),
      .I_TLB_VPN_2_MMU           (vpn),
      .I_TLB_PPN_from_MMU_en     (rsp_en),
      .I_TLB_PPN_from_MMU        (rsp_ppn),
      .I_TLB_from_MMU_page_fault (rsp_fault),
      .walker_busy               (busy),
      .mem                       (mem_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Walk with the bench acting as memory. gd = grant stall cycles,
   // rd = extra rvalid delay beyond the minimum one cycle after grant.
   // ecyc = response cycle counted from the accept edge (cycle 0).
   task automatic walk(input logic [19:0] v, input logic [19:0] pgd, input int lvls,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic [31:0] a2, input logic [31:0] d2,
                       input int gd, input int rd,
                       input logic [19:0] eppn, input logic efault, input int ecyc,
                       input bit fl_resp);
      int c0;
      logic [31:0] a, d;
      vpn = v; pgd_base = pgd; en = 1'b1;
      tick();
      c0 = cyc;
      for (int l = 0; l < lvls; l++) begin
         a = (l == 0) ? a1 : a2;
         d = (l == 0) ? d1 : d2;
         for (int g = 0; g < gd; g++) begin
            chk("req_stall", {31'b0, mem_if.mem_req}, 32'd1);
            chk("addr_stall", mem_if.mem_addr, a);
            tick();
         end
         chk("req", {31'b0, mem_if.mem_req}, 32'd1);
         chk("addr", mem_if.mem_addr, a);
         mem_if.mem_gnt = 1'b1;
         tick();
         mem_if.mem_gnt = 1'b0;
         chk("req_drop", {31'b0, mem_if.mem_req}, 32'd0);
         repeat (rd) tick();
         mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = d;
         chk("no_early_resp", {31'b0, rsp_en}, 32'd0);
         tick();
         mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
      end
      en = 1'b0;
      if (fl_resp) begin
         flush = 1'b1;
         #1;
         chk("resp_suppressed", {31'b0, rsp_en}, 32'd0);
      end else begin
         chk("resp_en", {31'b0, rsp_en}, 32'd1);
         chk("resp_ppn", {12'b0, rsp_ppn}, {12'b0, eppn});
         chk("resp_fault", {31'b0, rsp_fault}, {31'b0, efault});
         chk("latency", cyc - c0 + 1, ecyc);
      end
      tick();
      flush = 1'b0;
      chk("pulse_single", {31'b0, rsp_en}, 32'd0);
      chk("busy_after", {31'b0, busy}, 32'd0);
      chk("req_after", {31'b0, mem_if.mem_req}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; en = 1'b0; vpn = '0; pgd_base = '0;
      mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_en", {31'b0, rsp_en}, 32'd0);
      chk("rst_ppn", {12'b0, rsp_ppn}, 32'd0);
      chk("rst_fault", {31'b0, rsp_fault}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_req", {31'b0, mem_if.mem_req}, 32'd0);
      chk("rst_addr", mem_if.mem_addr, 32'd0);

      // two-level hit: L1 {0x00100,0x048,00}, L2 {0x00200,0x345,00}
      walk(20'h12345, 20'h00100, 2, 32'h00100120, 32'h00200001,
           32'h00200D14, 32'h00ABC005, 0, 0, 20'h00ABC, 1'b0, 5, 1'b0);
      // superpage: PDE[31:22]=0x013, VPN[21:12]=0x345 -> {0x013,0x345} = 0x04F45
      walk(20'h12345, 20'h00100, 1, 32'h00100120, 32'h04C00007,
           32'h0, 32'h0, 0, 0, 20'h04F45, 1'b0, 3, 1'b0);
      // PDE invalid
      walk(20'h12345, 20'h00100, 1, 32'h00100120, 32'h00200000,
           32'h0, 32'h0, 0, 0, 20'h0, 1'b1, 3, 1'b0);
      // PTE not executable
      walk(20'h12345, 20'h00100, 2, 32'h00100120, 32'h00200001,
           32'h00200D14, 32'h00ABC001, 0, 0, 20'h0, 1'b1, 5, 1'b0);
      // leaf PDE not executable
      walk(20'h12345, 20'h00100, 1, 32'h00100120, 32'h04C00003,
           32'h0, 32'h0, 0, 0, 20'h0, 1'b1, 3, 1'b0);
      // different indices: VPN 0xFFC01 -> L1 idx 0x3FF, L2 idx 0x001
      walk(20'hFFC01, 20'h0A000, 2, 32'h0A000FFC, 32'h00300001,
           32'h00300004, 32'h12345005, 0, 0, 20'h12345, 1'b0, 5, 1'b0);
      // back-pressure: 3 grant stalls + 2 rvalid delays per level -> cycle 15
      walk(20'h12345, 20'h00100, 2, 32'h00100120, 32'h00200001,
           32'h00200D14, 32'h00ABC005, 3, 2, 20'h00ABC, 1'b0, 15, 1'b0);

      // flush in L1_WAIT, rvalid arrives two cycles later
      vpn = 20'h12345; pgd_base = 20'h00100; en = 1'b1;
      tick();
      mem_if.mem_gnt = 1'b1;
      tick();
      mem_if.mem_gnt = 1'b0;
      flush = 1'b1; en = 1'b0;
      tick();
      flush = 1'b0;
      chk("drain_busy", {31'b0, busy}, 32'd1);
      tick();
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00200001;
      chk("drain_busy_rv", {31'b0, busy}, 32'd1);
      tick();
      mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
      chk("drain_idle", {31'b0, busy}, 32'd0);
      chk("drain_no_resp", {31'b0, rsp_en}, 32'd0);
      chk("drain_no_req", {31'b0, mem_if.mem_req}, 32'd0);
      walk(20'h12345, 20'h00100, 2, 32'h00100120, 32'h00200001,
           32'h00200D14, 32'h00ABC005, 0, 0, 20'h00ABC, 1'b0, 5, 1'b0);

      // flush in L1_REQ without grant: back to idle, request dropped
      en = 1'b1;
      tick();
      chk("flreq_req", {31'b0, mem_if.mem_req}, 32'd1);
      flush = 1'b1; en = 1'b0;
      tick();
      flush = 1'b0;
      chk("flreq_drop", {31'b0, mem_if.mem_req}, 32'd0);
      chk("flreq_idle", {31'b0, busy}, 32'd0);

      // flush together with grant: grant counts, drain the read
      en = 1'b1;
      tick();
      flush = 1'b1; en = 1'b0; mem_if.mem_gnt = 1'b1;
      tick();
      flush = 1'b0; mem_if.mem_gnt = 1'b0;
      chk("flgnt_busy", {31'b0, busy}, 32'd1);
      chk("flgnt_req", {31'b0, mem_if.mem_req}, 32'd0);
      mem_if.mem_rvalid = 1'b1;
      tick();
      mem_if.mem_rvalid = 1'b0;
      chk("flgnt_idle", {31'b0, busy}, 32'd0);
      chk("flgnt_no_resp", {31'b0, rsp_en}, 32'd0);

      // flush in RESP suppresses the pulse
      walk(20'h12345, 20'h00100, 1, 32'h00100120, 32'h04C00007,
           32'h0, 32'h0, 0, 0, 20'h04F45, 1'b0, 3, 1'b1);

      // request with flush in IDLE is not accepted
      en = 1'b1; flush = 1'b1;
      tick();
      en = 1'b0; flush = 1'b0;
      chk("flidle_busy", {31'b0, busy}, 32'd0);
      chk("flidle_req", {31'b0, mem_if.mem_req}, 32'd0);

      // reset mid-L2_WAIT followed by a stray rvalid
      en = 1'b1;
      tick();
      mem_if.mem_gnt = 1'b1;
      tick();
      mem_if.mem_gnt = 1'b0;
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00200001;
      tick();
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_gnt = 1'b1;
      tick();
      mem_if.mem_gnt = 1'b0;
      chk("l2wait_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_req", {31'b0, mem_if.mem_req}, 32'd0);
      chk("mrst_addr", mem_if.mem_addr, 32'd0);
      chk("mrst_en", {31'b0, rsp_en}, 32'd0);
      mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00ABC005;
      tick();
      mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
      chk("stray_en", {31'b0, rsp_en}, 32'd0);
      chk("stray_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("stray_en2", {31'b0, rsp_en}, 32'd0);
      chk("stray_ppn", {12'b0, rsp_ppn}, 32'd0);
      chk("stray_fault", {31'b0, rsp_fault}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
